// File: rtl/interp_loop_ctrl.sv
// interp_loop_ctrl: two-level row/column loop sequencer for the interpolation datapath.
// Optional ABORT input is enabled by defining INTERP_LOOP_CTRL_ABORT_EN.
module interp_loop_ctrl #(
  parameter int CNT_W    = 4,
  parameter int LAST_ROW = 15,
  parameter int N_COLS   = 4,
  parameter int COL_W    = 3
) (
  input  logic             CLK,
  input  logic             RST_ASYNC_N,
  input  logic             START,
  input  logic             STALL,
  input  logic [CNT_W-1:0] CNT_VALUE,
  output logic             CNT_WRITE_EN,
  output logic [CNT_W-1:0] CNT_DATA,
  output logic             SAMPLE_VALID,
  output logic [COL_W-1:0] COL_IDX,
  output logic             ROW_LAST,
  output logic             BUSY,
  output logic             DONE
`ifdef INTERP_LOOP_CTRL_ABORT_EN
  ,
  input  logic             ABORT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_FINISH
  } state_t;

  localparam logic [CNT_W-1:0] LAST_V   = CNT_W'(LAST_ROW);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [COL_W-1:0] col_d;
  logic             done_d;
  logic             abort;
  logic             active;
  logic             advance;
  logic             col_end;
  logic             row_end;

`ifdef INTERP_LOOP_CTRL_ABORT_EN
  assign abort = ABORT;
`else
  assign abort = 1'b0;
`endif

  assign active  = (state_q != S_IDLE);
  assign advance = (state_q == S_RUN) && !STALL && !abort;
  assign col_end = (COL_IDX == COL_LAST);
  // >= so an out-of-range counter terminates instead of wrapping
  assign row_end = (CNT_VALUE >= LAST_V);

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_q <= S_IDLE;
      COL_IDX <= '0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      COL_IDX <= col_d;
      DONE    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = COL_IDX;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        col_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (advance) begin
          if (col_end) begin
            col_d = '0;
            if (row_end) state_d = S_FINISH;
          end else begin
            col_d = COL_IDX + 1'b1;
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && active) begin
      state_d = S_IDLE;
      col_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    CNT_WRITE_EN = 1'b0;
    CNT_DATA     = '0;
    SAMPLE_VALID = 1'b0;
    ROW_LAST     = 1'b0;
    BUSY         = active;
    unique case (state_q)
      S_CLEAR: CNT_WRITE_EN = 1'b1;
      S_RUN: begin
        ROW_LAST = (CNT_VALUE == LAST_V);
        if (advance) begin
          SAMPLE_VALID = 1'b1;
          if (col_end && !row_end) begin
            CNT_WRITE_EN = 1'b1;
            CNT_DATA     = CNT_VALUE + 1'b1;
          end
        end
      end
      default: ;
    endcase
    // abort parks the counter at zero on the way out
    if (abort && active) begin
      CNT_WRITE_EN = 1'b1;
      CNT_DATA     = '0;
      SAMPLE_VALID = 1'b0;
    end
  end

endmodule

// File: tb/tb_interp_loop_ctrl.sv
// tb_interp_loop_ctrl: directed bench for interp_loop_ctrl, default and
// LAST_ROW=0/N_COLS=1 instances, each with its own counter register.
module tb_interp_loop_ctrl;

  logic CLK = 1'b0;
  logic RST_ASYNC_N = 1'b0;
  logic START = 1'b0, STALL = 1'b0;
  logic START1 = 1'b0, STALL1 = 1'b0;
`ifdef INTERP_LOOP_CTRL_ABORT_EN
  logic ABORT = 1'b0, ABORT1 = 1'b0;
`endif

  logic [3:0] cnt0, cnt1, data0, data1;
  logic [2:0] col0, col1;
  logic we0, sv0, rl0, busy0, done0;
  logic we1, sv1, rl1, busy1, done1;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  interp_loop_ctrl u0 (
    .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N), .START(START), .STALL(STALL),
    .CNT_VALUE(cnt0), .CNT_WRITE_EN(we0), .CNT_DATA(data0),
    .SAMPLE_VALID(sv0), .COL_IDX(col0), .ROW_LAST(rl0), .BUSY(busy0),
    .DONE(done0)
`ifdef INTERP_LOOP_CTRL_ABORT_EN
    , .ABORT(ABORT)
`endif
  );

  interp_loop_ctrl #(.LAST_ROW(0), .N_COLS(1)) u1 (
    .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N), .START(START1), .STALL(STALL1),
    .CNT_VALUE(cnt1), .CNT_WRITE_EN(we1), .CNT_DATA(data1),
    .SAMPLE_VALID(sv1), .COL_IDX(col1), .ROW_LAST(rl1), .BUSY(busy1),
    .DONE(done1)
`ifdef INTERP_LOOP_CTRL_ABORT_EN
    , .ABORT(ABORT1)
`endif
  );

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (we0) cnt0 <= data0;
      if (we1) cnt1 <= data1;
    end
  end

  task automatic test_reset();
    int strobes;
    RST_ASYNC_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy0); end
    checks++; if ({sv0, we0, done0} !== 3'b000) begin errors++; $display("FAIL rst_strobes got %b want 000", {sv0, we0, done0}); end
    checks++; if ({col0, data0} !== 7'd0) begin errors++; $display("FAIL rst_col_data got %0d/%0d want 0/0", col0, data0); end
    RST_ASYNC_N = 1'b1;
    strobes = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      if (sv0 || we0 || done0 || busy0 || sv1 || we1 || done1 || busy1) strobes++;
    end
    checks++; if (strobes !== 0) begin errors++; $display("FAIL idle_strobes got %0d want 0", strobes); end
  endtask

  task automatic test_full_run();
    int samples, writes, done_at, dones, col_bad, data_bad, rl_n;
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    @(negedge CLK);
    checks++; if ({we0, busy0} !== 2'b11) begin errors++; $display("FAIL clear_we_busy got %b want 11", {we0, busy0}); end
    checks++; if (data0 !== 4'd0) begin errors++; $display("FAIL clear_data got %0d want 0", data0); end
    samples = 0; writes = 0; done_at = 0; dones = 0; col_bad = 0; data_bad = 0; rl_n = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      if (sv0) begin
        if (int'(col0) != samples % 4) col_bad++;
        samples++;
      end
      if (we0) begin
        writes++;
        if (int'(data0) != writes) data_bad++;
      end
      if (rl0) rl_n++;
      if (done0) begin
        dones++;
        if (done_at == 0) done_at = k;
      end
    end
    checks++; if (samples !== 64) begin errors++; $display("FAIL full_samples got %0d want 64", samples); end
    checks++; if (writes !== 15) begin errors++; $display("FAIL full_writes got %0d want 15", writes); end
    checks++; if (col_bad !== 0) begin errors++; $display("FAIL full_col_seq got %0d bad want 0", col_bad); end
    checks++; if (data_bad !== 0) begin errors++; $display("FAIL full_data_seq got %0d bad want 0", data_bad); end
    checks++; if (rl_n !== 4) begin errors++; $display("FAIL full_row_last got %0d want 4", rl_n); end
    checks++; if (done_at !== 66) begin errors++; $display("FAIL full_done_at got %0d want 66", done_at); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL full_done_pulses got %0d want 1", dones); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL full_busy_end got %b want 0", busy0); end
  endtask

  task automatic test_stall();
    int samples, writes, done_at, st_n, stall_bad;
    bit rel_seen;
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    samples = 0; writes = 0; done_at = 0; st_n = 0; stall_bad = 0; rel_seen = 0;
    for (int k = 1; k <= 85; k++) begin
      @(posedge CLK); #1;
      if (col0 == 3'd3 && cnt0 == 4'd5 && st_n < 3) begin
        STALL = 1'b1;
        st_n++;
      end else begin
        STALL = 1'b0;
      end
      @(negedge CLK);
      if (STALL) begin
        if (we0 || sv0) stall_bad++;
      end else if (st_n == 3 && !rel_seen) begin
        rel_seen = 1;
        checks++; if (we0 !== 1'b1) begin errors++; $display("FAIL stall_release_we got %b want 1", we0); end
        checks++; if (data0 !== 4'd6) begin errors++; $display("FAIL stall_release_data got %0d want 6", data0); end
      end
      if (sv0) samples++;
      if (we0) writes++;
      if (done0 && done_at == 0) done_at = k;
    end
    STALL = 1'b0;
    checks++; if (st_n !== 3) begin errors++; $display("FAIL stall_cycles got %0d want 3", st_n); end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_strobes got %0d want 0", stall_bad); end
    checks++; if (samples !== 64) begin errors++; $display("FAIL stall_samples got %0d want 64", samples); end
    checks++; if (writes !== 15) begin errors++; $display("FAIL stall_writes got %0d want 15", writes); end
    checks++; if (done_at !== 69) begin errors++; $display("FAIL stall_done_at got %0d want 69", done_at); end
  endtask

  task automatic test_boundary();
    int samples, dones;
    @(posedge CLK); #1 START1 = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if ({we1, busy1, data1} !== 6'b110000) begin errors++; $display("FAIL b_clear got %b want 110000", {we1, busy1, data1}); end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if ({sv1, we1, rl1, col1} !== 6'b101000) begin errors++; $display("FAIL b_run got %b want 101000", {sv1, we1, rl1, col1}); end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if ({busy1, sv1, done1} !== 3'b100) begin errors++; $display("FAIL b_finish got %b want 100", {busy1, sv1, done1}); end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if ({done1, busy1} !== 2'b10) begin errors++; $display("FAIL b_done got %b want 10", {done1, busy1}); end
    @(posedge CLK); #1 START1 = 1'b0;
    @(negedge CLK);
    checks++; if ({we1, busy1} !== 2'b11) begin errors++; $display("FAIL b_restart got %b want 11", {we1, busy1}); end
    samples = 0; dones = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      if (sv1) samples++;
      if (we1) begin
        checks++; errors++;
        $display("FAIL b_incr_write got %0d want none", data1);
      end
      if (done1) dones++;
    end
    checks++; if (samples !== 1) begin errors++; $display("FAIL b_samples got %0d want 1", samples); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL b_dones got %0d want 1", dones); end
  endtask

  task automatic test_reset_midrun();
    int guard, writes, dones;
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    guard = 0;
    while (cnt0 != 4'd7 && guard < 100) begin
      @(posedge CLK); #1;
      guard++;
    end
    checks++; if (cnt0 !== 4'd7) begin errors++; $display("FAIL mid_reach7 got %0d want 7", cnt0); end
    RST_ASYNC_N = 1'b0;
    #1;
    checks++; if ({busy0, sv0, we0, done0} !== 4'b0000) begin errors++; $display("FAIL mid_outputs got %b want 0000", {busy0, sv0, we0, done0}); end
    checks++; if ({col0, cnt0} !== 7'd0) begin errors++; $display("FAIL mid_col_cnt got %0d/%0d want 0/0", col0, cnt0); end
    repeat (2) @(posedge CLK);
    #1 RST_ASYNC_N = 1'b1;
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if ({sv0, col0, cnt0} !== 8'b1_000_0000) begin errors++; $display("FAIL mid_restart got %b want 10000000", {sv0, col0, cnt0}); end
    writes = 0; dones = 0;
    for (int k = 2; k <= 70; k++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      if (we0) writes++;
      if (done0) dones++;
    end
    checks++; if (writes !== 15 || dones !== 1) begin errors++; $display("FAIL mid_rerun got %0d/%0d want 15/1", writes, dones); end
  endtask

`ifdef INTERP_LOOP_CTRL_ABORT_EN
  task automatic test_abort();
    int guard, dones;
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    guard = 0;
    while (!(cnt0 == 4'd9 && col0 == 3'd2) && guard < 100) begin
      @(posedge CLK); #1;
      guard++;
    end
    ABORT = 1'b1;
    @(negedge CLK);
    checks++; if ({we0, sv0, data0} !== 6'b100000) begin errors++; $display("FAIL abort_cycle got %b want 100000", {we0, sv0, data0}); end
    @(posedge CLK); #1 ABORT = 1'b0;
    @(negedge CLK);
    checks++; if ({busy0, cnt0, col0} !== 8'd0) begin errors++; $display("FAIL abort_idle got %b want 0", {busy0, cnt0, col0}); end
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      if (done0) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_done got %0d want 0", dones); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_run();
    test_stall();
    test_boundary();
    test_reset_midrun();
`ifdef INTERP_LOOP_CTRL_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
